// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register file and its writeback arbiter.
//   RF_DATA_W / RF_ADDR_W : default data width and register index width
//   NUM_REGS              : number of architectural registers (2**RF_ADDR_W)
//   RF_MAX_WAIT           : default ALU starvation limit for the arbiter
//   grant_t               : which requester owns the write port this cycle
//   wait_state_t          : arbitration priority state (load-first / forced ALU)
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int NUM_REGS    = 2 ** RF_ADDR_W;
    localparam int RF_MAX_WAIT = 3;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_MEM,
        GNT_ALU
    } grant_t;

    typedef enum logic {
        PRIO_MEM,
        FORCE_ALU
    } wait_state_t;

endpackage

// File: rtl/contador_espera.sv
// -----------------------------------------------------------------------------
// contador_espera
// Saturating count of consecutive cycles an ALU writeback request has lost,
// plus the PRIO_MEM / FORCE_ALU priority state it drives.
//   CLK       : clock, rising edge
//   RESET_N   : asynchronous active-low reset
//   aluValid  : ALU writeback request present
//   aluGrant  : ALU owns the write port this cycle
//   forceAlu  : ALU must win a contested cycle (state FORCE_ALU)
// The current state is held in r_state (wait_state_t) and the count in r_count
// so checkers can observe both directly.
// -----------------------------------------------------------------------------
module contador_espera
    import regfile_pkg::*;
#(
    parameter int MAX_WAIT = RF_MAX_WAIT
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic aluValid,
    input  logic aluGrant,
    output logic forceAlu
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    wait_state_t      r_state;
    wait_state_t      w_state_next;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_count <= '0;
            r_state <= PRIO_MEM;
        end else begin
            r_count <= w_count_next;
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_count_next = r_count;
        w_state_next = r_state;

        // Stall cycles count as losses: only a grant or a withdrawn request clears.
        if (!aluValid || aluGrant) begin
            w_count_next = '0;
        end else if (r_count != CNT_MAX) begin
            w_count_next = r_count + 1'b1;
        end

        // Switching on the next count lets the ALU win on the very cycle after
        // its MAX_WAIT-th loss.
        case (r_state)
            PRIO_MEM:  if (w_count_next == CNT_MAX) w_state_next = FORCE_ALU;
            FORCE_ALU: if (aluGrant || !aluValid)   w_state_next = PRIO_MEM;
            default:   w_state_next = PRIO_MEM;
        endcase
    end

    assign forceAlu = (r_state == FORCE_ALU);

endmodule

// File: rtl/arbitro_escritura_registros.sv
// -----------------------------------------------------------------------------
// arbitro_escritura_registros
// Arbitrates the single register-file write port between ALU and load
// writeback requests. Loads win contested cycles unless the ALU has lost
// MAX_WAIT cycles in a row. The write port is registered; x0 writes are
// accepted but never enabled. pendingMask flags every register with a write
// that has not yet reached the register file.
//   CLK, RESET_N                  : clock (rising), async active-low reset
//   aluValid/aluReg/aluData       : ALU request;  aluReady = accepted this cycle
//   memValid/memReg/memData       : load request; memReady = accepted this cycle
//   wbStall                       : no grants this cycle
//   writeReg/writeData/RegWrite   : registered register-file write port
//   pendingMask                   : one bit per register with an unretired write
// Handshake: a request transfers in any cycle where valid && ready. A requester
// holds valid, reg and data stable until accepted; ready depends only on the
// valids, wbStall and the arbitration state, never on the request payload.
// -----------------------------------------------------------------------------
module arbitro_escritura_registros
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int MAX_WAIT = RF_MAX_WAIT
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   aluValid,
    input  logic [ADDR_W-1:0]      aluReg,
    input  logic [DATA_W-1:0]      aluData,
    output logic                   aluReady,
    input  logic                   memValid,
    input  logic [ADDR_W-1:0]      memReg,
    input  logic [DATA_W-1:0]      memData,
    output logic                   memReady,
    input  logic                   wbStall,
    output logic [ADDR_W-1:0]      writeReg,
    output logic [DATA_W-1:0]      writeData,
    output logic                   RegWrite,
    output logic [2**ADDR_W-1:0]   pendingMask
);

    grant_t              w_grant;
    logic                w_force_alu;
    logic                w_alu_grant;
    logic [ADDR_W-1:0]   w_win_reg;
    logic [DATA_W-1:0]   w_win_data;
    logic [2**ADDR_W-1:0] w_pending;

    logic [ADDR_W-1:0]   r_write_reg;
    logic [DATA_W-1:0]   r_write_data;
    logic                r_reg_write;

    contador_espera #(
        .MAX_WAIT (MAX_WAIT)
    ) u_contador_espera (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .aluValid (aluValid),
        .aluGrant (w_alu_grant),
        .forceAlu (w_force_alu)
    );

    // Grant decision; held off entirely while in reset so nothing is accepted.
    always_comb begin
        w_grant = GNT_NONE;
        if (RESET_N && !wbStall) begin
            if (aluValid && memValid) begin
                w_grant = w_force_alu ? GNT_ALU : GNT_MEM;
            end else if (memValid) begin
                w_grant = GNT_MEM;
            end else if (aluValid) begin
                w_grant = GNT_ALU;
            end
        end
    end

    assign w_alu_grant = (w_grant == GNT_ALU);
    assign aluReady    = w_alu_grant;
    assign memReady    = (w_grant == GNT_MEM);

    always_comb begin
        w_win_reg  = memReg;
        w_win_data = memData;
        if (w_grant == GNT_ALU) begin
            w_win_reg  = aluReg;
            w_win_data = aluData;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_reg_write  <= 1'b0;
        end else if (w_grant != GNT_NONE) begin
            r_write_reg  <= w_win_reg;
            r_write_data <= w_win_data;
            r_reg_write  <= (w_win_reg != '0);
        end else begin
            r_reg_write  <= 1'b0;
        end
    end

    assign writeReg  = r_write_reg;
    assign writeData = r_write_data;
    assign RegWrite  = r_reg_write;

    // Waiting requests plus the write in flight in the output stage. x0 is
    // hardwired, so it can never be a hazard.
    always_comb begin
        w_pending = '0;
        if (RESET_N) begin
            if (aluValid && !aluReady) w_pending[aluReg] = 1'b1;
            if (memValid && !memReady) w_pending[memReg] = 1'b1;
        end
        if (r_reg_write) w_pending[r_write_reg] = 1'b1;
        w_pending[0] = 1'b0;
    end

    assign pendingMask = w_pending;

endmodule

// File: tb/tb_arbitro_escritura_registros.sv
module tb_arbitro_escritura_registros;
    import regfile_pkg::*;

    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int MAX_WAIT = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          a_v = 1'b0;
    logic [AW-1:0] a_r = '0;
    logic [DW-1:0] a_d = '0;
    logic          m_v = 1'b0;
    logic [AW-1:0] m_r = '0;
    logic [DW-1:0] m_d = '0;
    logic          stall = 1'b0;
    logic          alu_ready, mem_ready, reg_write;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic [31:0]   pending_mask;

    arbitro_escritura_registros #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .CLK         (clk),
        .RESET_N     (rst_n),
        .aluValid    (a_v),
        .aluReg      (a_r),
        .aluData     (a_d),
        .aluReady    (alu_ready),
        .memValid    (m_v),
        .memReg      (m_r),
        .memData     (m_d),
        .memReady    (mem_ready),
        .wbStall     (stall),
        .writeReg    (write_reg),
        .writeData   (write_data),
        .RegWrite    (reg_write),
        .pendingMask (pending_mask)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [AW+DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // alu_lost: consecutive cycles the ALU has been waiting without a grant.
    int            alu_lost = 0;
    logic          out_we = 1'b0;
    logic [AW-1:0] out_reg = '0;
    logic          alu_acc = 1'b0;
    logic          mem_acc = 1'b0;

    // One clock cycle: inputs are already applied; check readys and mask at
    // the falling edge, predict the write, then advance to just after the edge.
    task automatic cycle();
        grant_t      g;
        logic [31:0] exp_mask;
        @(negedge clk);
        g = GNT_NONE;
        if (!stall) begin
            if (a_v && m_v) g = (alu_lost >= MAX_WAIT) ? GNT_ALU : GNT_MEM;
            else if (m_v)   g = GNT_MEM;
            else if (a_v)   g = GNT_ALU;
        end
        chk("aluReady", 64'(alu_ready), 64'(g == GNT_ALU));
        chk("memReady", 64'(mem_ready), 64'(g == GNT_MEM));

        exp_mask = '0;
        if (a_v && g != GNT_ALU) exp_mask[a_r] = 1'b1;
        if (m_v && g != GNT_MEM) exp_mask[m_r] = 1'b1;
        if (out_we) exp_mask[out_reg] = 1'b1;
        exp_mask[0] = 1'b0;
        chk("pendingMask", 64'(pending_mask), 64'(exp_mask));

        out_we = 1'b0;
        if (g == GNT_ALU) begin
            out_reg = a_r;
            out_we  = (a_r != 0);
            if (a_r != 0) exp_q.push_back({a_r, a_d});
        end else if (g == GNT_MEM) begin
            out_reg = m_r;
            out_we  = (m_r != 0);
            if (m_r != 0) exp_q.push_back({m_r, m_d});
        end

        if (a_v && g != GNT_ALU) alu_lost++;
        else                     alu_lost = 0;

        alu_acc = (g == GNT_ALU);
        mem_acc = (g == GNT_MEM);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_reg();
        if ($urandom_range(0, 7) == 0) return '0;
        return AW'($urandom_range(0, 31));
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && reg_write) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got reg %0d data %0h expected no write", write_reg, write_data);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                chk("write_port", 64'({write_reg, write_data}), 64'(e));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset with both requests presented.
        a_v = 1'b1; a_r = 5'd3; a_d = 32'h11;
        m_v = 1'b1; m_r = 5'd4; m_d = 32'h22;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_aluReady", 64'(alu_ready), 64'(0));
        chk("rst_memReady", 64'(mem_ready), 64'(0));
        chk("rst_RegWrite", 64'(reg_write), 64'(0));
        chk("rst_writeReg", 64'(write_reg), 64'(0));
        chk("rst_writeData", 64'(write_data), 64'(0));
        chk("rst_pendingMask", 64'(pending_mask), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // First grant after reset goes to the load.
        cycle();
        chk("first_grant_mem", 64'(mem_acc), 64'(1));
        m_v = 1'b0;
        cycle();
        a_v = 1'b0;
        cycle();
        cycle();

        // Single ALU request.
        a_v = 1'b1; a_r = 5'd5; a_d = 32'hDEADBEEF;
        cycle();
        a_v = 1'b0;
        cycle();
        cycle();

        // Contention: new load every cycle, ALU held until accepted.
        a_v = 1'b1; a_r = 5'd9; a_d = 32'hA0A0A0A0;
        for (int i = 0; i < 6; i++) begin
            m_v = 1'b1; m_r = AW'(10 + i); m_d = $urandom();
            cycle();
            if (i < 5) chk("contention_alu_grant", 64'(alu_acc), 64'(i == 3));
            if (alu_acc) begin a_r = 5'd20; a_d = $urandom(); end
        end
        a_v = 1'b0; m_v = 1'b0;
        repeat (3) cycle();

        // x0 load is accepted but not written.
        m_v = 1'b1; m_r = 5'd0; m_d = 32'h1234;
        cycle();
        chk("x0_accept", 64'(mem_acc), 64'(1));
        m_v = 1'b0;
        cycle();
        cycle();

        // Same destination from both.
        a_v = 1'b1; a_r = 5'd7; a_d = 32'd1;
        m_v = 1'b1; m_r = 5'd7; m_d = 32'd2;
        cycle();
        m_v = 1'b0;
        cycle();
        a_v = 1'b0;
        cycle();
        cycle();

        // Stall with both valid: ALU wins first on release.
        a_v = 1'b1; a_r = 5'd3; a_d = 32'h33;
        m_v = 1'b1; m_r = 5'd4; m_d = 32'h44;
        stall = 1'b1;
        repeat (4) cycle();
        stall = 1'b0;
        cycle();
        chk("stall_release_alu", 64'(alu_acc), 64'(1));
        a_v = 1'b0;
        cycle();
        m_v = 1'b0;
        repeat (2) cycle();

        // Randomized traffic; requests stay stable until accepted.
        for (int n = 0; n < 400; n++) begin
            if (alu_acc) a_v = 1'b0;
            if (mem_acc) m_v = 1'b0;
            if (!a_v && $urandom_range(0, 99) < 70) begin
                a_v = 1'b1; a_r = rand_reg(); a_d = $urandom();
            end
            if (!m_v && $urandom_range(0, 99) < 60) begin
                m_v = 1'b1; m_r = rand_reg(); m_d = $urandom();
            end
            stall = ($urandom_range(0, 99) < 12);
            cycle();
        end

        // Drain.
        a_v = 1'b0; m_v = 1'b0; stall = 1'b0;
        repeat (3) cycle();
        chk("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
